// File: rtl/nco_cnt.sv
// NCO-timed modulo counter: an accumulator ticks every num enabled cycles and each tick advances a mod-MOD counter.
// Define NCO_CNT_DOWN_EN to add the dir port and allow counting down.
module nco_cnt #(
  parameter int NCO_W = 32,
  parameter int CNT_W = 6,
  parameter int MOD   = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCO_W-1:0] num,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
`ifdef NCO_CNT_DOWN_EN
  input  logic             dir,
`endif
  output logic [CNT_W-1:0] out,
  output logic             tick,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] TOP = CNT_W'(MOD - 1);

  logic [NCO_W-1:0] acc;
  logic             count_down;
  logic             period_end;
  logic             cnt_wraps;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] load_sat;

`ifdef NCO_CNT_DOWN_EN
  assign count_down = dir;
`else
  assign count_down = 1'b0;
`endif

  // The >= compare (not ==) lets a shrinking num end the period at once instead of waiting for acc to roll over.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
    period_end = 1'b0;
    cnt_wraps  = 1'b0;
    cnt_next   = out;
    load_sat   = load_val;

    if (en) begin
      period_end = (num <= NCO_W'(1)) || (acc >= num - NCO_W'(1));
    end

    if (load_val > TOP) begin
      load_sat = TOP;
    end

    if (count_down) begin
      cnt_wraps = (out == '0);
      cnt_next  = cnt_wraps ? TOP : out - CNT_W'(1);
    end else begin
      cnt_wraps = (out == TOP);
      cnt_next  = cnt_wraps ? '0 : out + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      out  <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of its neighbours.
      tick <= period_end;

      if (en) begin
        acc <= period_end ? '0 : acc + NCO_W'(1);
      end

      // A load wins over a tick advance and suppresses the wrap strobe.
      if (load) begin
        out  <= load_sat;
        wrap <= 1'b0;
      end else if (period_end) begin
        out  <= cnt_next;
        wrap <= cnt_wraps;
      end else begin
        wrap <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nco_cnt.sv
// Scoreboard bench for nco_cnt: a behavioural model queues the expected outputs of every edge it drives.
module tb_nco_cnt;

  localparam int NCO_W = 32;
  localparam int CNT_W = 6;
  localparam int MOD   = 60;
`ifdef NCO_CNT_DOWN_EN
  localparam bit DOWN_EN = 1'b1;
`else
  localparam bit DOWN_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             load;
  logic             dir;
  logic [NCO_W-1:0] num;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] out;
  logic             tick;
  logic             wrap;

  nco_cnt #(.NCO_W(NCO_W), .CNT_W(CNT_W), .MOD(MOD)) dut (
    .clk      (clk),
    .rst      (rst),
    .num      (num),
    .en       (en),
    .load     (load),
    .load_val (load_val),
`ifdef NCO_CNT_DOWN_EN
    .dir      (dir),
`endif
    .out      (out),
    .tick     (tick),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CNT_W-1:0] out;
    logic             tick;
    logic             wrap;
  } obs_t;

  obs_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int tick_cnt;
  int wrap_cnt;

  logic [NCO_W-1:0] m_acc;
  logic [CNT_W-1:0] m_out;
  logic             m_tick;
  logic             m_wrap;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_acc  = '0;
    m_out  = '0;
    m_tick = 1'b0;
    m_wrap = 1'b0;
  endtask

  // Advance the model by one edge from the inputs now being driven, and queue its outputs.
  task automatic predict();
    logic [63:0]      filled;
    logic [63:0]      period;
    bit               fire;
    logic [CNT_W-1:0] sat;
    filled = {32'd0, m_acc} + 64'd1;
    period = {32'd0, num};
    fire   = en && (filled >= period);
    m_tick = fire;
    if (en) m_acc = fire ? '0 : m_acc + 1;
    if (load) begin
      sat    = (load_val >= MOD) ? CNT_W'(MOD - 1) : load_val;
      m_out  = sat;
      m_wrap = 1'b0;
    end else if (fire) begin
      if (DOWN_EN && dir) begin
        if (m_out == 0) begin m_out = CNT_W'(MOD - 1); m_wrap = 1'b1; end
        else begin m_out = m_out - 1; m_wrap = 1'b0; end
      end else begin
        if (m_out == CNT_W'(MOD - 1)) begin m_out = '0; m_wrap = 1'b1; end
        else begin m_out = m_out + 1; m_wrap = 1'b0; end
      end
    end else begin
      m_wrap = 1'b0;
    end
    sb_q.push_back({m_out, m_tick, m_wrap});
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic step();
    obs_t e;
    predict();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check($sformatf("cycle@%0t", $time), {out, tick, wrap}, e);
    if (tick) tick_cnt++;
    if (wrap) wrap_cnt++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    en       = 1'b0;
    load     = 1'b0;
    dir      = 1'b0;
    load_val = '0;
    #1;
    check("reset_outputs", {out, tick, wrap}, '0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick_cnt = 0;
    wrap_cnt = 0;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int first_tick;
    num = 32'd5;
    do_reset();

    // Steady period of 5: 80 ticks, one wrap at the 60th.
    en = 1'b1;
    run(400);
    check("num5_ticks", tick_cnt, 80);
    check("num5_wraps", wrap_cnt, 1);

    // Degenerate periods tick every enabled cycle.
    do_reset();
    en  = 1'b1;
    num = 32'd0;
    run(60);
    num = 32'd1;
    run(60);
    check("num01_ticks", tick_cnt, 120);
    check("num01_wraps", wrap_cnt, 2);

    // Period shrinks below the accumulator mid-period.
    do_reset();
    en  = 1'b1;
    num = 32'd100;
    run(50);
    check("num100_no_tick", tick_cnt, 0);
    num = 32'd10;
    step();
    check("num_drop_tick", tick, 1'b1);
    tick_cnt = 0;
    run(30);
    check("num10_ticks", tick_cnt, 3);

    // Load at MOD-1 with en low, then load an oversize value on a wrapping tick edge.
    do_reset();
    load = 1'b1; load_val = 6'd59;
    step();
    load = 1'b0; num = 32'd2; en = 1'b1;
    run(1);
    load = 1'b1; load_val = 6'd63;
    step();
    check("load_sat_out", out, 6'd59);
    check("load_sat_wrap", wrap, 1'b0);
    check("load_sat_tick", tick, 1'b1);
    load = 1'b0;
    run(2);
    check("wrap_after_load_out", out, 6'd0);
    check("wrap_after_load_wrap", wrap, 1'b1);

    // Load with en low; everything else holds.
    en = 1'b0; load = 1'b1; load_val = 6'd7;
    step();
    check("load_noen_out", out, 6'd7);
    check("load_noen_tick", tick, 1'b0);
    load = 1'b0;
    run(5);
    check("hold_noen_out", out, 6'd7);

`ifdef NCO_CNT_DOWN_EN
    do_reset();
    dir = 1'b1; num = 32'd2; en = 1'b1;
    run(2);
    check("down_wrap_out", out, 6'd59);
    check("down_wrap_wrap", wrap, 1'b1);
    dir = 1'b0;
`endif

    // Asynchronous reset mid-period, then a fresh first period.
    do_reset();
    num = 32'd3; en = 1'b1;
    run(10);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out", out, '0);
    check("async_rst_strobes", {tick, wrap}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    first_tick = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (tick && first_tick == 0) first_tick = i;
    end
    check("first_tick_after_rst", first_tick, 3);

    // Random mix of enable, load, direction and period changes.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if (i % 20 == 0) num = $urandom_range(0, 6);
      en       = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 19) == 0);
      load_val = CNT_W'($urandom_range(0, 63));
      dir      = DOWN_EN ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
